// File: rtl/mem_access.sv
// mem_access: load/store unit between the pipeline and a simple req/ack bus.
//
// A one-cycle start samples mem_op/addr/wdata. Loads and stores go through a
// single bus request (REQ) that waits for bus_ack or a timeout; NOPs complete
// immediately. Every accepted start produces exactly one one-cycle done pulse
// unless reset intervenes.
//
// Handshake: bus_req stays high from REQ entry until the edge that samples
// bus_ack=1 (or the timeout fires). bus_addr/bus_be/bus_we/bus_wdata are
// stable for the whole time bus_req is high. bus_ack is only looked at in REQ.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN traps misaligned halfword/word
// accesses (done + err_misalign, no bus request). Without it, the low address
// bits that do not fit the access size are ignored.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle request (ignored while busy)
//   mem_op[3:0]       0 LB,1 LH,2 LW,3 LBU,4 LHU,8 SB,9 SH,10 SW, else NOP
//   addr[31:0]        byte address
//   wdata[31:0]       store data
//   busy              state is not IDLE (pipeline stall)
//   done              one-cycle completion pulse
//   rdata[31:0]       extended load result (held between loads)
//   err_misalign      error pulse aligned with done
//   err_timeout       error pulse aligned with done
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   bus request side
//   bus_ack/bus_rdata                          bus response side
//   dbg_state[1:0]    current FSM state (0 IDLE, 1 REQ, 2 DONE)
module mem_access #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Last counter value before the timeout fires: REQ lasts TIMEOUT_CYC cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        done_q;
    logic        err_mis_q;
    logic        err_to_q;
    logic [31:0] rdata_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    size_t       size_q;
    logic        sign_q;
    logic [1:0]  off_q;

    // Decode of the incoming request
    logic        is_ld;
    logic        is_st;
    logic        is_sign;
    size_t       size_in;
    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    always_comb begin
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_sign = 1'b0;
        size_in = SZ_B;
        case (mem_op)
            4'd0:    begin is_ld = 1'b1; is_sign = 1'b1; size_in = SZ_B; end
            4'd1:    begin is_ld = 1'b1; is_sign = 1'b1; size_in = SZ_H; end
            4'd2:    begin is_ld = 1'b1; size_in = SZ_W; end
            4'd3:    begin is_ld = 1'b1; size_in = SZ_B; end
            4'd4:    begin is_ld = 1'b1; size_in = SZ_H; end
            4'd8:    begin is_st = 1'b1; size_in = SZ_B; end
            4'd9:    begin is_st = 1'b1; size_in = SZ_H; end
            4'd10:   begin is_st = 1'b1; size_in = SZ_W; end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misaligned = (is_ld || is_st) &&
                     (((size_in == SZ_H) && addr[0]) ||
                      ((size_in == SZ_W) && (addr[1:0] != 2'b00)));
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata;
        case (size_in)
            SZ_B: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be_d    = 4'b0011 << {addr[1], 1'b0};
                wdata_d = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction from the latched size/sign/offset
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_d;

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            SZ_B:    ext_d = {{24{sign_q & byte_sel[7]}}, byte_sel};
            SZ_H:    ext_d = {{16{sign_q & half_sel[15]}}, half_sel};
            default: ext_d = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            done_q      <= 1'b0;
            err_mis_q   <= 1'b0;
            err_to_q    <= 1'b0;
            rdata_q     <= 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            size_q      <= SZ_B;
            sign_q      <= 1'b0;
            off_q       <= 2'd0;
        end else begin
            // Pulses default low; only set on DONE entry.
            done_q    <= 1'b0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if ((is_ld || is_st) && !misaligned) begin
                            state_q     <= S_REQ;
                            cnt_q       <= 8'd0;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= is_st;
                            bus_addr_q  <= {addr[31:2], 2'b00};
                            bus_be_q    <= be_d;
                            bus_wdata_q <= wdata_d;
                            size_q      <= size_in;
                            sign_q      <= is_sign;
                            off_q       <= addr[1:0];
                        end else begin
                            // NOP or trapped access: straight to DONE.
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            err_mis_q <= misaligned;
                            if (misaligned) begin
                                rdata_q <= 32'd0;
                            end
                        end
                    end
                end
                S_REQ: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (bus_ack) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        if (!bus_we_q) begin
                            rdata_q <= ext_d;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        err_to_q  <= 1'b1;
                        rdata_q   <= 32'd0;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign err_misalign = err_mis_q;
    assign err_timeout  = err_to_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err_misalign;
    logic        err_timeout;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_op(mem_op), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .err_misalign(err_misalign), .err_timeout(err_timeout),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present a one-cycle start; returns 1ns after the sampling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        start = 1'b1; mem_op = op; addr = a; wdata = d;
        @(posedge clk); #1;
        start = 1'b0; mem_op = 4'd5; addr = 32'd0; wdata = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_cmp++; if (bus_req !== 1'b0 || bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus got req=%b we=%b exp 0/0", bus_req, bus_we); end
        n_cmp++; if (err_misalign !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b exp 00", err_misalign, err_timeout); end
        n_cmp++; if (rdata !== 32'd0 || bus_addr !== 32'd0 || bus_be !== 4'd0 || bus_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_regs got rdata=%h addr=%h be=%b wd=%h exp zeros", rdata, bus_addr, bus_be, bus_wdata); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Load with ack in the first REQ cycle.
    task automatic test_load(input string nm, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] bus_d, input logic [3:0] exp_be,
                             input logic [31:0] exp_rd);
        issue(op, a, 32'd0);
        bus_ack = 1'b1; bus_rdata = bus_d;
        @(negedge clk);
        n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_be !== exp_be || bus_addr !== {a[31:2], 2'b00})
            begin n_fail++; $display("FAIL %s_req got req=%b we=%b be=%b addr=%h exp 1/0/%b/%h", nm, bus_req, bus_we, bus_be, bus_addr, exp_be, {a[31:2], 2'b00}); end
        @(posedge clk); #1 bus_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || rdata !== exp_rd || bus_req !== 1'b0 || err_timeout !== 1'b0)
            begin n_fail++; $display("FAIL %s_done got done=%b rdata=%h req=%b to=%b exp 1/%h/0/0", nm, done, rdata, bus_req, err_timeout, exp_rd); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL %s_idle got done=%b busy=%b exp 0/0", nm, done, busy); end
    endtask

    task automatic test_store_byte();
        issue(4'd8, 32'h0000_1003, 32'h0000_00A5);
        bus_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h1000 || bus_be !== 4'b1000 || bus_wdata !== 32'hA5A5A5A5)
            begin n_fail++; $display("FAIL sb_req got req=%b we=%b addr=%h be=%b wd=%h exp 1/1/00001000/1000/a5a5a5a5", bus_req, bus_we, bus_addr, bus_be, bus_wdata); end
        @(posedge clk); #1 bus_ack = 1'b0;
        @(negedge clk);
        // rdata must still hold the preceding LH result
        n_cmp++; if (done !== 1'b1 || rdata !== 32'hFFFF8001 || bus_we !== 1'b0)
            begin n_fail++; $display("FAIL sb_done got done=%b rdata=%h we=%b exp 1/ffff8001/0", done, rdata, bus_we); end
    endtask

    task automatic test_store_half();
        issue(4'd9, 32'h0000_1002, 32'h1234_BEEF);
        bus_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_be !== 4'b1100 || bus_wdata !== 32'hBEEFBEEF)
            begin n_fail++; $display("FAIL sh_req got be=%b wd=%h exp 1100/beefbeef", bus_be, bus_wdata); end
        @(posedge clk); #1 bus_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int reqs;
        bit seen;
        reqs = 0; seen = 1'b0;
        issue(4'd2, 32'h0000_4000, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; break; end
            if (bus_req === 1'b1) reqs++;
        end
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL to_done got none exp done within 40 cycles"); end
        n_cmp++; if (reqs != 16) begin n_fail++; $display("FAIL to_req_cycles got %0d exp 16", reqs); end
        n_cmp++; if (err_timeout !== 1'b1 || rdata !== 32'd0 || bus_req !== 1'b0 || err_misalign !== 1'b0)
            begin n_fail++; $display("FAIL to_flags got to=%b rdata=%h req=%b mis=%b exp 1/0/0/0", err_timeout, rdata, bus_req, err_misalign); end
        @(negedge clk);
        n_cmp++; if (err_timeout !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_pulse got to=%b busy=%b exp 0/0", err_timeout, busy); end
    endtask

    // Ack arriving in the 16th REQ cycle beats the timeout.
    task automatic test_ack_at_limit();
        issue(4'd2, 32'h0000_4008, 32'd0);
        repeat (15) @(posedge clk);
        #1 bus_ack = 1'b1; bus_rdata = 32'h0123_4567;
        @(negedge clk);
        n_cmp++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL lim_req got %b exp 1", bus_req); end
        @(posedge clk); #1 bus_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || err_timeout !== 1'b0 || rdata !== 32'h01234567)
            begin n_fail++; $display("FAIL lim_done got done=%b to=%b rdata=%h exp 1/0/01234567", done, err_timeout, rdata); end
        @(negedge clk);
    endtask

    task automatic test_misalign();
        issue(4'd10, 32'h0000_3002, 32'hCAFE_F00D);
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || err_misalign !== 1'b1 || bus_req !== 1'b0)
            begin n_fail++; $display("FAIL mis_trap got done=%b mis=%b req=%b exp 1/1/0", done, err_misalign, bus_req); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL mis_after got busy=%b req=%b exp 0/0", busy, bus_req); end
`else
        bus_ack = 1'b1; bus_rdata = 32'd0;
        @(negedge clk);
        n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h3000 || bus_be !== 4'b1111 || bus_wdata !== 32'hCAFEF00D)
            begin n_fail++; $display("FAIL mis_req got req=%b addr=%h be=%b wd=%h exp 1/00003000/1111/cafef00d", bus_req, bus_addr, bus_be, bus_wdata); end
        @(posedge clk); #1 bus_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || err_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_done got done=%b mis=%b exp 1/0", done, err_misalign); end
        @(negedge clk);
`endif
    endtask

    task automatic test_nop();
        issue(4'd5, 32'h0000_0040, 32'd0);
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b1 || bus_req !== 1'b0 || rdata !== 32'h01234567)
            begin n_fail++; $display("FAIL nop_done got done=%b busy=%b req=%b rdata=%h exp 1/1/0/01234567", done, busy, bus_req, rdata); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL nop_idle got done=%b busy=%b exp 0/0", done, busy); end
    endtask

    // Start while busy must not launch a second transaction.
    task automatic test_busy_ignore();
        bit extra;
        extra = 1'b0;
        issue(4'd2, 32'h0000_7000, 32'd0);
        start = 1'b1; mem_op = 4'd0; addr = 32'h0000_7001;
        @(posedge clk); #1 start = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h0000_0011;
        @(posedge clk); #1 bus_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || rdata !== 32'h00000011) begin n_fail++; $display("FAIL busy_done got done=%b rdata=%h exp 1/00000011", done, rdata); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || bus_req !== 1'b0) extra = 1'b1;
        end
        n_cmp++; if (extra !== 1'b0) begin n_fail++; $display("FAIL busy_ignore got extra activity exp none"); end
    endtask

    task automatic test_reset_mid();
        bit bad;
        bad = 1'b0;
        issue(4'd2, 32'h0000_5000, 32'd0);
        start = 1'b1; mem_op = 4'd8; addr = 32'h0000_6001; wdata = 32'h77;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        n_cmp++; if (bus_req !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0)
            begin n_fail++; $display("FAIL rstmid_async got req=%b busy=%b st=%0d exp 0/0/0", bus_req, busy, dbg_state); end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || bus_req !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet got activity after reset exp none"); end
        n_cmp++; if (bus_addr !== 32'd0 || bus_wdata !== 32'd0 || rdata !== 32'd0)
            begin n_fail++; $display("FAIL rstmid_regs got addr=%h wd=%h rdata=%h exp zeros", bus_addr, bus_wdata, rdata); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_op = 4'd5; addr = 32'd0; wdata = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        test_reset();
        test_load("lb",  4'd0, 32'h0000_2002, 32'h12F0_3456, 4'b0100, 32'hFFFF_FFF0);
        test_load("lbu", 4'd3, 32'h0000_2002, 32'h12F0_3456, 4'b0100, 32'h0000_00F0);
        test_load("lhu", 4'd4, 32'h0000_2000, 32'h8001_7FFE, 4'b0011, 32'h0000_7FFE);
        test_load("lw",  4'd2, 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        test_load("lh",  4'd1, 32'h0000_2002, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
        test_store_byte();
        @(negedge clk);
        test_store_half();
        test_timeout();
        test_ack_at_limit();
        test_nop();
        test_misalign();
        test_busy_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard time limit in case the design stalls somewhere unbounded.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

endmodule
